mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and single-op sequencer in front of the
// 512 MiB data RAM. Port 0 is load/store, port 1 is instruction fetch. One RAM
// operation is in flight at a time: IDLE grants and latches, ISSUE pulses the
// RAM valid and samples its exception, WAIT holds the command until the RAM
// reports completion, then the owner gets a one-cycle done pulse.

package mem_arbiter_pkg;
  // RAM exception encoding shared with the RAM block.
  parameter int unsigned EXCEPTION_LEN = 4;
  parameter logic [EXCEPTION_LEN-1:0] EXCEP_OK                = 4'd0;
  parameter logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ  = 4'd5;
  parameter logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_WRITE = 4'd6;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,

  // Port 0: load/store requester
  input  logic                     m0_req_In,
  input  logic [31:0]              m0_addr_In,
  input  logic [31:0]              m0_data_In,
  input  logic [1:0]               m0_width_In,
  input  logic                     m0_isRead_In,
  output logic                     m0_grant_Out,
  output logic                     m0_done_Out,
  output logic [31:0]              m0_data_Out,
  output logic [EXCEPTION_LEN-1:0] m0_exception_Out,

  // Port 1: instruction-fetch requester
  input  logic                     m1_req_In,
  input  logic [31:0]              m1_addr_In,
  input  logic [31:0]              m1_data_In,
  input  logic [1:0]               m1_width_In,
  input  logic                     m1_isRead_In,
  output logic                     m1_grant_Out,
  output logic                     m1_done_Out,
  output logic [31:0]              m1_data_Out,
  output logic [EXCEPTION_LEN-1:0] m1_exception_Out,

  // RAM request interface
  output logic [31:0]              ram_addr_Out,
  output logic [31:0]              ram_data_Out,
  output logic [1:0]               ram_width_Out,
  output logic                     ram_isRead_Out,
  output logic                     ram_valid_Out,
  input  logic [31:0]              ram_data_In,
  input  logic                     ram_ok_In,
  input  logic [EXCEPTION_LEN-1:0] ram_exception_In
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  state_e                   state_q;
  logic                     last_q;   // port granted most recently
  logic                     owner_q;  // port that owns the in-flight op
  logic                     ram_valid_q;
  logic [31:0]              ram_addr_q;
  logic [31:0]              ram_data_q;
  logic [1:0]               ram_width_q;
  logic                     ram_is_read_q;
  logic [EXCEPTION_LEN-1:0] exc_q;    // exception sampled in ISSUE

  logic                     m0_done_q;
  logic                     m1_done_q;
  logic [31:0]              m0_data_q;
  logic [31:0]              m1_data_q;
  logic [EXCEPTION_LEN-1:0] m0_exc_q;
  logic [EXCEPTION_LEN-1:0] m1_exc_q;

  logic                     any_req;
  logic                     win;      // winning port when any_req is set
  logic                     grant;    // a grant happens this cycle
  logic [31:0]              sel_addr;
  logic [31:0]              sel_data;
  logic [1:0]               sel_width;
  logic                     sel_is_read;

  // Round-robin winner selection and field mux for the winning requester.
  always_comb begin
    any_req = m0_req_In | m1_req_In;
    win     = 1'b0;
    if (m0_req_In && m1_req_In) begin
      // Contention: the port that was not served last goes first.
      win = ~last_q;
    end else if (m1_req_In) begin
      win = 1'b1;
    end
    sel_addr    = win ? m1_addr_In   : m0_addr_In;
    sel_data    = win ? m1_data_In   : m0_data_In;
    sel_width   = win ? m1_width_In  : m0_width_In;
    sel_is_read = win ? m1_isRead_In : m0_isRead_In;
  end

  // Grants are combinational, only in IDLE, and suppressed while in reset.
  always_comb begin
    grant        = (state_q == StIdle) && !rst && any_req;
    m0_grant_Out = grant && !win;
    m1_grant_Out = grant && win;
  end

  // Arbitration FSM with all registered outputs; reset abandons any op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      last_q        <= 1'b1;
      owner_q       <= 1'b0;
      ram_valid_q   <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_q    <= '0;
      ram_width_q   <= '0;
      ram_is_read_q <= 1'b0;
      exc_q         <= EXCEP_OK;
      m0_done_q     <= 1'b0;
      m1_done_q     <= 1'b0;
      m0_data_q     <= '0;
      m1_data_q     <= '0;
      m0_exc_q      <= EXCEP_OK;
      m1_exc_q      <= EXCEP_OK;
    end else begin
      // Single-cycle pulses default low.
      m0_done_q   <= 1'b0;
      m1_done_q   <= 1'b0;
      ram_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_q       <= win;
            last_q        <= win;
            ram_addr_q    <= sel_addr;
            ram_data_q    <= sel_data;
            ram_width_q   <= sel_width;
            ram_is_read_q <= sel_is_read;
            ram_valid_q   <= 1'b1;
            state_q       <= StIssue;
          end
        end
        StIssue: begin
          // The RAM presents its exception combinationally alongside valid.
          exc_q   <= ram_exception_In;
          state_q <= StWait;
        end
        StWait: begin
          if (ram_ok_In) begin
            if (owner_q) begin
              m1_done_q <= 1'b1;
              m1_exc_q  <= exc_q;
              if (ram_is_read_q) begin
                m1_data_q <= ram_data_In;
              end
            end else begin
              m0_done_q <= 1'b1;
              m0_exc_q  <= exc_q;
              if (ram_is_read_q) begin
                m0_data_q <= ram_data_In;
              end
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m0_done_Out      = m0_done_q;
  assign m1_done_Out      = m1_done_q;
  assign m0_data_Out      = m0_data_q;
  assign m1_data_Out      = m1_data_q;
  assign m0_exception_Out = m0_exc_q;
  assign m1_exception_Out = m1_exc_q;
  assign ram_addr_Out     = ram_addr_q;
  assign ram_data_Out     = ram_data_q;
  assign ram_width_Out    = ram_width_q;
  assign ram_isRead_Out   = ram_is_read_q;
  assign ram_valid_Out    = ram_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural RAM model, a reference
// memory, and a per-port scoreboard of expected completions.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam logic [31:0] RamLimit = 32'h2000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                     m0_req_In, m1_req_In;
  logic [31:0]              m0_addr_In, m1_addr_In, m0_data_In, m1_data_In;
  logic [1:0]               m0_width_In, m1_width_In;
  logic                     m0_isRead_In, m1_isRead_In;
  logic                     m0_grant_Out, m1_grant_Out, m0_done_Out, m1_done_Out;
  logic [31:0]              m0_data_Out, m1_data_Out;
  logic [EXCEPTION_LEN-1:0] m0_exception_Out, m1_exception_Out;
  logic [31:0]              ram_addr_Out, ram_data_Out, ram_data_In;
  logic [1:0]               ram_width_Out;
  logic                     ram_isRead_Out, ram_valid_Out, ram_ok_In;
  logic [EXCEPTION_LEN-1:0] ram_exception_In;

  mem_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .m0_req_In        (m0_req_In),
    .m0_addr_In       (m0_addr_In),
    .m0_data_In       (m0_data_In),
    .m0_width_In      (m0_width_In),
    .m0_isRead_In     (m0_isRead_In),
    .m0_grant_Out     (m0_grant_Out),
    .m0_done_Out      (m0_done_Out),
    .m0_data_Out      (m0_data_Out),
    .m0_exception_Out (m0_exception_Out),
    .m1_req_In        (m1_req_In),
    .m1_addr_In       (m1_addr_In),
    .m1_data_In       (m1_data_In),
    .m1_width_In      (m1_width_In),
    .m1_isRead_In     (m1_isRead_In),
    .m1_grant_Out     (m1_grant_Out),
    .m1_done_Out      (m1_done_Out),
    .m1_data_Out      (m1_data_Out),
    .m1_exception_Out (m1_exception_Out),
    .ram_addr_Out     (ram_addr_Out),
    .ram_data_Out     (ram_data_Out),
    .ram_width_Out    (ram_width_Out),
    .ram_isRead_Out   (ram_isRead_Out),
    .ram_valid_Out    (ram_valid_Out),
    .ram_data_In      (ram_data_In),
    .ram_ok_In        (ram_ok_In),
    .ram_exception_In (ram_exception_In)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Cycle counter: incremented on every rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model ----------------
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          stall_cycles = 0;
  logic        ram_busy = 1'b0;
  int          ram_cnt = 0;

  always_comb begin
    ram_exception_In = EXCEP_OK;
    if (ram_valid_Out && ram_addr_Out >= RamLimit) begin
      ram_exception_In = ram_isRead_Out ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
    end
  end

  always @(posedge clk) begin
    ram_ok_In <= 1'b0;
    if (rst) begin
      ram_busy    <= 1'b0;
      ram_data_In <= '0;
    end else if (ram_valid_Out) begin
      if (ram_addr_Out < RamLimit) begin
        if (ram_isRead_Out) begin
          ram_data_In <= ram_mem.exists(ram_addr_Out) ? ram_mem[ram_addr_Out] : 32'h0;
        end else begin
          ram_mem[ram_addr_Out] = ram_data_Out;
        end
      end else begin
        ram_data_In <= '0;
      end
      if (stall_cycles == 0) begin
        ram_ok_In <= 1'b1;
      end else begin
        ram_busy <= 1'b1;
        ram_cnt  <= stall_cycles;
      end
    end else if (ram_busy) begin
      if (ram_cnt == 1) begin
        ram_ok_In <= 1'b1;
        ram_busy  <= 1'b0;
      end
      ram_cnt <= ram_cnt - 1;
    end
  end

  // ---------------- Scoreboard ----------------
  typedef struct {
    logic [31:0]              data;
    logic [EXCEPTION_LEN-1:0] exc;
    int                       due;
  } exp_t;

  exp_t                     sb [2][$];
  logic [31:0]              hold_data [2];
  logic [EXCEPTION_LEN-1:0] hold_exc [2];
  int                       next_valid = -1;

  // Push on grant, pop on done, and check held outputs every cycle.
  always @(negedge clk) begin
    logic                     g [2];
    logic                     d [2];
    logic [31:0]              od [2];
    logic [EXCEPTION_LEN-1:0] oe [2];
    logic [31:0]              a;
    logic [31:0]              wd;
    logic                     rd;
    exp_t                     e;
    g[0] = m0_grant_Out; g[1] = m1_grant_Out;
    d[0] = m0_done_Out;  d[1] = m1_done_Out;
    od[0] = m0_data_Out; od[1] = m1_data_Out;
    oe[0] = m0_exception_Out; oe[1] = m1_exception_Out;
    if (rst) begin
      sb[0].delete();
      sb[1].delete();
      for (int p = 0; p < 2; p++) begin
        hold_data[p] = '0;
        hold_exc[p]  = EXCEP_OK;
      end
      next_valid = -1;
    end else begin
      check_eq("grant_onehot", 32'(g[0] & g[1]), 32'h0);
      check_eq("ram_valid", 32'(ram_valid_Out), 32'(cyc == next_valid));
      for (int p = 0; p < 2; p++) begin
        if (d[p]) begin
          if (sb[p].size() == 0) begin
            check_eq(p == 0 ? "m0_done_unexpected" : "m1_done_unexpected", 32'h1, 32'h0);
          end else begin
            e = sb[p].pop_front();
            check_eq(p == 0 ? "m0_done_cycle" : "m1_done_cycle", 32'(cyc), 32'(e.due));
            hold_data[p] = e.data;
            hold_exc[p]  = e.exc;
          end
        end else if (sb[p].size() > 0 && sb[p][0].due < cyc) begin
          check_eq(p == 0 ? "m0_done_missing" : "m1_done_missing", 32'h0, 32'h1);
          void'(sb[p].pop_front());
        end
        check_eq(p == 0 ? "m0_data" : "m1_data", od[p], hold_data[p]);
        check_eq(p == 0 ? "m0_exc" : "m1_exc", 32'(oe[p]), 32'(hold_exc[p]));
      end
      for (int p = 0; p < 2; p++) begin
        if (g[p]) begin
          a  = (p == 0) ? m0_addr_In : m1_addr_In;
          wd = (p == 0) ? m0_data_In : m1_data_In;
          rd = (p == 0) ? m0_isRead_In : m1_isRead_In;
          e.due = cyc + 3 + stall_cycles;
          if (a >= RamLimit) begin
            e.exc  = rd ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
            e.data = rd ? 32'h0 : hold_data[p];
          end else begin
            e.exc = EXCEP_OK;
            if (rd) begin
              e.data = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
            end else begin
              e.data   = hold_data[p];
              ref_mem[a] = wd;
            end
          end
          sb[p].push_back(e);
          next_valid = cyc + 1;
        end
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic set_port(input int p, input logic req, input logic [31:0] a,
                          input logic [31:0] d, input logic rd);
    if (p == 0) begin
      m0_req_In = req; m0_addr_In = a; m0_data_In = d; m0_isRead_In = rd; m0_width_In = 2'd2;
    end else begin
      m1_req_In = req; m1_addr_In = a; m1_data_In = d; m1_isRead_In = rd; m1_width_In = 2'd2;
    end
  endtask

  // Raise a request, wait (bounded) for its grant, then drop it.
  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] d,
                       input logic rd, output int gcyc);
    logic got;
    got  = 1'b0;
    gcyc = -1;
    set_port(p, 1'b1, a, d, rd);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if ((p == 0 && m0_grant_Out) || (p == 1 && m1_grant_Out)) begin
        got  = 1'b1;
        gcyc = cyc;
      end
    end
    if (!got) check_eq("grant_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    if (p == 0) m0_req_In = 1'b0; else m1_req_In = 1'b0;
  endtask

  // Wait (bounded) until every expected completion has been seen.
  task automatic drain();
    logic empty;
    empty = 1'b0;
    for (int i = 0; i < 60 && !empty; i++) begin
      @(negedge clk);
      empty = (sb[0].size() == 0) && (sb[1].size() == 0);
    end
    if (!empty) check_eq("drain_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- Test sequence ----------------
  initial begin
    int gc;
    int g_port [$];
    int g_cyc [$];
    rst = 1'b1;
    set_port(0, 1'b0, '0, '0, 1'b0);
    set_port(1, 1'b0, '0, '0, 1'b0);
    ram_mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ram_valid", 32'(ram_valid_Out), 32'h0);
    check_eq("rst_ram_addr", ram_addr_Out, 32'h0);
    check_eq("rst_m0_exc", 32'(m0_exception_Out), 32'(EXCEP_OK));
    check_eq("rst_m1_data", m1_data_Out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read on port 0
    issue(0, 32'h100, 32'h0, 1'b1, gc);
    drain();
    check_eq("single_rd_data", m0_data_Out, 32'hDEAD_BEEF);
    check_eq("single_rd_m1_untouched", m1_data_Out, 32'h0);

    // Write then read on port 1
    issue(1, 32'h40, 32'h1234_5678, 1'b0, gc);
    drain();
    check_eq("wr_keeps_data", m1_data_Out, 32'h0);
    issue(1, 32'h40, 32'h0, 1'b1, gc);
    drain();
    check_eq("rd_after_wr", m1_data_Out, 32'h1234_5678);

    // Out-of-range accesses
    issue(0, 32'h2000_0000, 32'h0, 1'b1, gc);
    drain();
    check_eq("exc_rd", 32'(m0_exception_Out), 32'(EXCEP_INVALID_MEM_READ));
    issue(0, 32'h2000_0000, 32'hAAAA_5555, 1'b0, gc);
    drain();
    check_eq("exc_wr", 32'(m0_exception_Out), 32'(EXCEP_INVALID_MEM_WRITE));

    // Stalled RAM: command must hold and port 1 must wait
    stall_cycles = 5;
    set_port(0, 1'b1, 32'h100, 32'h0, 1'b1);
    gc = -1;
    for (int i = 0; i < 20 && gc < 0; i++) begin
      @(negedge clk);
      if (m0_grant_Out) gc = cyc;
    end
    if (gc < 0) check_eq("stall_grant_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    m0_req_In = 1'b0;
    set_port(1, 1'b1, 32'h40, 32'h0, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check_eq("stall_no_grant", 32'(m1_grant_Out), 32'h0);
      check_eq("stall_cmd_addr", ram_addr_Out, 32'h100);
      check_eq("stall_cmd_rd", 32'(ram_isRead_Out), 32'h1);
    end
    stall_cycles = 0;
    @(negedge clk);
    check_eq("stall_then_grant", 32'(m1_grant_Out), 32'h1);
    @(posedge clk); #1;
    m1_req_In = 1'b0;
    drain();

    // Contention from reset: alternate m0, m1 every 3 cycles
    rst = 1'b1;
    set_port(0, 1'b1, 32'h100, 32'h0, 1'b1);
    set_port(1, 1'b1, 32'h40, 32'h0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (m0_grant_Out) begin g_port.push_back(0); g_cyc.push_back(cyc); end
      if (m1_grant_Out) begin g_port.push_back(1); g_cyc.push_back(cyc); end
    end
    @(posedge clk); #1;
    m0_req_In = 1'b0;
    m1_req_In = 1'b0;
    check_eq("cont_grant_count", 32'(g_port.size()), 32'd4);
    for (int i = 0; i < 4 && i < g_port.size(); i++) begin
      check_eq("cont_order", 32'(g_port[i]), 32'(i % 2));
      check_eq("cont_spacing", 32'(g_cyc[i] - g_cyc[0]), 32'(3 * i));
    end
    drain();

    // Reset in WAIT: no done, all outputs cleared, then m0 first
    issue(1, 32'h40, 32'h0, 1'b1, gc);
    @(posedge clk); #1;
    rst = 1'b1;
    set_port(0, 1'b1, 32'h100, 32'h0, 1'b1);
    set_port(1, 1'b1, 32'h40, 32'h0, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rstmid_m0_grant", 32'(m0_grant_Out), 32'h0);
    check_eq("rstmid_m1_grant", 32'(m1_grant_Out), 32'h0);
    check_eq("rstmid_m1_done", 32'(m1_done_Out), 32'h0);
    check_eq("rstmid_m0_done", 32'(m0_done_Out), 32'h0);
    check_eq("rstmid_ram_valid", 32'(ram_valid_Out), 32'h0);
    check_eq("rstmid_ram_addr", ram_addr_Out, 32'h0);
    check_eq("rstmid_ram_data", ram_data_Out, 32'h0);
    check_eq("rstmid_ram_width", 32'(ram_width_Out), 32'h0);
    check_eq("rstmid_ram_rd", 32'(ram_isRead_Out), 32'h0);
    check_eq("rstmid_m0_data", m0_data_Out, 32'h0);
    check_eq("rstmid_m1_data", m1_data_Out, 32'h0);
    check_eq("rstmid_m0_exc", 32'(m0_exception_Out), 32'(EXCEP_OK));
    check_eq("rstmid_m1_exc", 32'(m1_exception_Out), 32'(EXCEP_OK));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_m0_first", 32'(m0_grant_Out), 32'h1);
    check_eq("post_rst_m1_wait", 32'(m1_grant_Out), 32'h0);
    @(posedge clk); #1;
    m0_req_In = 1'b0;
    m1_req_In = 1'b0;
    drain();
    check_eq("sb_empty", 32'(sb[0].size() + sb[1].size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
